// File: rtl/bus_sequencer.sv
// Control sequencer for a two-register, single-bus datapath with an ALU (A/G latches).
// Decodes LOAD/MOV/ADD/SUB into per-step bus enables from the current state and the captured instruction.
module bus_sequencer #(
    parameter logic SUBCODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] instr,
    output logic       busy,
    output logic       done,
    output logic       R0in,
    output logic       R1in,
    output logic       R0out,
    output logic       R1out,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       Extern,
    output logic       AddSub
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_ir;
    logic [1:0] w_op;
    logic       w_rx;
    logic       w_ry;

    assign w_op = r_ir[3:2];
    assign w_rx = r_ir[1];
    assign w_ry = r_ir[0];

    // The instruction register only loads on an accepted start, so it stays fixed for the whole instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ir    <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_ir <= instr;
            end
        end
    end

    always_comb begin
        w_next = IDLE;
        busy   = 1'b0;
        done   = 1'b0;
        R0in   = 1'b0;
        R1in   = 1'b0;
        R0out  = 1'b0;
        R1out  = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        Extern = 1'b0;
        AddSub = 1'b0;

        case (r_state)
            IDLE: begin
                w_next = start ? T1 : IDLE;
            end

            T1: begin
                busy = 1'b1;
                case (w_op)
                    OP_LOAD: begin
                        Extern = 1'b1;
                        R0in   = ~w_rx;
                        R1in   = w_rx;
                        done   = 1'b1;
                        w_next = IDLE;
                    end
                    OP_MOV: begin
                        R0out  = ~w_ry;
                        R1out  = w_ry;
                        R0in   = ~w_rx;
                        R1in   = w_rx;
                        done   = 1'b1;
                        w_next = IDLE;
                    end
                    default: begin
                        R0out  = ~w_rx;
                        R1out  = w_rx;
                        Ain    = 1'b1;
                        w_next = T2;
                    end
                endcase
            end

            // T2/T3 are only meaningful for ALU ops; any other op there falls back to IDLE with no enables.
            T2: begin
                busy = 1'b1;
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    R0out  = ~w_ry;
                    R1out  = w_ry;
                    Gin    = 1'b1;
                    AddSub = (w_op == OP_SUB) ? SUBCODE : ~SUBCODE;
                    w_next = T3;
                end
            end

            T3: begin
                busy = 1'b1;
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    Gout = 1'b1;
                    R0in = ~w_rx;
                    R1in = w_rx;
                    done = 1'b1;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Testbench for bus_sequencer: directed vector table through a scoreboard queue, then a random
// stream checked against a latency model, bus exclusion, and done/busy accounting.
module tb_bus_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] instr;
    logic       busy, done, R0in, R1in, R0out, R1out, Ain, Gin, Gout, Extern, AddSub;

    localparam logic [10:0] BUSY   = 11'h400;
    localparam logic [10:0] DONE   = 11'h200;
    localparam logic [10:0] R0IN   = 11'h100;
    localparam logic [10:0] R1IN   = 11'h080;
    localparam logic [10:0] R0OUT  = 11'h040;
    localparam logic [10:0] R1OUT  = 11'h020;
    localparam logic [10:0] AIN    = 11'h010;
    localparam logic [10:0] GIN    = 11'h008;
    localparam logic [10:0] GOUT   = 11'h004;
    localparam logic [10:0] EXT    = 11'h002;
    localparam logic [10:0] ADDSUB = 11'h001;

    typedef struct {
        logic        rst;
        logic        start;
        logic [3:0]  instr;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] expQ[$];
    int          doneCycleQ[$];
    int          checks   = 0;
    int          failures = 0;

    bus_sequencer #(.SUBCODE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .busy(busy), .done(done), .R0in(R0in), .R1in(R1in),
        .R0out(R0out), .R1out(R1out), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .Extern(Extern), .AddSub(AddSub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] packOut();
        return {busy, done, R0in, R1in, R0out, R1out, Ain, Gin, Gout, Extern, AddSub};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic [3:0] i,
                          input logic [10:0] e, input string n);
        vec_t v;
        v.rst = r; v.start = s; v.instr = i; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Drives one vector ahead of the edge and queues the outputs expected after it.
    task automatic applyStimulus(input vec_t v);
        logic [10:0] exp;
        rst   = v.rst;
        start = v.start;
        instr = v.instr;
        expQ.push_back(v.exp);
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        checkOutput(v.name, {21'd0, packOut()}, {21'd0, exp});
    endtask

    initial begin
        int left;
        int accepted;
        int aborted;
        int doneCount;
        int expCycle;
        logic [3:0] rInstr;
        logic rRst, rStart;

        rst = 1'b1; start = 1'b0; instr = 4'b0000;

        addVec(1, 1, 4'b0010, 11'h000, "reset0");
        addVec(1, 1, 4'b0010, 11'h000, "reset1");
        addVec(0, 0, 4'b0000, 11'h000, "postReset");
        addVec(0, 1, 4'b0010, BUSY|DONE|R1IN|EXT, "loadR1_T1");
        addVec(0, 0, 4'b0000, 11'h000, "loadR1_idle");
        addVec(0, 1, 4'b1001, BUSY|R0OUT|AIN, "addR0R1_T1");
        addVec(0, 0, 4'b0000, BUSY|R1OUT|GIN, "addR0R1_T2");
        addVec(0, 0, 4'b0000, BUSY|GOUT|R0IN|DONE, "addR0R1_T3");
        addVec(0, 0, 4'b0000, 11'h000, "addR0R1_idle");
        addVec(0, 1, 4'b1110, BUSY|R1OUT|AIN, "subR1R0_T1");
        addVec(0, 1, 4'b0000, BUSY|R0OUT|GIN|ADDSUB, "subR1R0_T2");
        addVec(0, 1, 4'b0000, BUSY|GOUT|R1IN|DONE, "subR1R0_T3");
        addVec(0, 1, 4'b0000, 11'h000, "subR1R0_idle");
        addVec(0, 1, 4'b0000, BUSY|DONE|R0IN|EXT, "loadR0_backToBack");
        addVec(0, 0, 4'b0000, 11'h000, "loadR0_idle");
        addVec(0, 1, 4'b0101, BUSY|DONE|R1OUT|R0IN, "movR0R1");
        addVec(0, 0, 4'b0000, 11'h000, "movR0R1_idle");
        addVec(0, 1, 4'b0111, BUSY|DONE|R1OUT|R1IN, "movR1R1");
        addVec(0, 0, 4'b0000, 11'h000, "movR1R1_idle");
        addVec(0, 1, 4'b1011, BUSY|R1OUT|AIN, "addR1R1_T1");
        addVec(0, 0, 4'b0000, BUSY|R1OUT|GIN, "addR1R1_T2");
        addVec(0, 0, 4'b0000, BUSY|GOUT|R1IN|DONE, "addR1R1_T3");
        addVec(0, 0, 4'b0000, 11'h000, "addR1R1_idle");
        addVec(0, 1, 4'b1001, BUSY|R0OUT|AIN, "abortT2_T1");
        addVec(0, 0, 4'b0000, BUSY|R1OUT|GIN, "abortT2_T2");
        addVec(1, 0, 4'b0000, 11'h000, "abortT2_reset");
        addVec(0, 0, 4'b0000, 11'h000, "abortT2_noDone0");
        addVec(0, 0, 4'b0000, 11'h000, "abortT2_noDone1");
        addVec(0, 1, 4'b1110, BUSY|R1OUT|AIN, "abortT1_T1");
        addVec(1, 1, 4'b0010, 11'h000, "abortT1_resetStart");
        addVec(0, 0, 4'b0000, 11'h000, "abortT1_idle");

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k]);
        end

        // Random phase: left counts remaining busy cycles as seen just after each edge.
        left = 0; accepted = 0; aborted = 0; doneCount = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc < 9990) begin
                rRst   = ($urandom_range(0, 49) == 0);
                rStart = 1'($urandom_range(0, 1));
                rInstr = 4'($urandom_range(0, 15));
            end else begin
                rRst = 1'b0; rStart = 1'b0; rInstr = 4'b0000;
            end
            rst = rRst; start = rStart; instr = rInstr;

            if (rRst) begin
                aborted += doneCycleQ.size();
                doneCycleQ.delete();
                left = 0;
            end else if (left > 0) begin
                left--;
            end else if (rStart) begin
                left = rInstr[3] ? 3 : 1;
                doneCycleQ.push_back(cyc + left - 1);
                accepted++;
            end

            @(posedge clk);
            #1;
            checkOutput("rndBusy", {31'd0, busy}, {31'd0, (left > 0)});
            checkOutput("rndDone", {31'd0, done}, {31'd0, (left == 1)});
            checkOutput("rndBusExcl", {31'd0, ($countones({R0out, R1out, Gout, Extern}) <= 1)}, 32'd1);
            checkOutput("rndDoneBusy", {31'd0, (!done || busy)}, 32'd1);
            if (done) begin
                doneCount++;
                if (doneCycleQ.size() == 0) begin
                    checkOutput("rndDoneUnexpected", 32'd1, 32'd0);
                end else begin
                    expCycle = doneCycleQ.pop_front();
                    checkOutput("rndDoneCycle", cyc, expCycle);
                end
            end
        end

        checkOutput("rndPending", doneCycleQ.size(), 32'd0);
        checkOutput("rndDoneCount", doneCount, accepted - aborted);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
